datapath_controller: RTL
========================

// Module: datapath_controller
// PURPOSE
// - Upstream control stage for the datapath (regfile, A/B/C regs, shifter, ALU, status Z).
// - Latches a 16-bit instruction, decodes it, and sequences a multi-cycle Moore FSM.
// - The FSM drives every datapath control strobe and the immediate on datapath_in.
// - Supports MOV Rn,#imm8; MOV Rd,Rm{,sh}; ADD; CMP; AND; MVN.
// - Handshake: s/w (start/wait).
// PARAMETERS
// - DW    16  datapath word width; instruction width is also DW.
// - RNUMW  3  register-number width (8 registers).
// PORTS
// - clk          in   1      rising-edge clock
// - reset_n      in   1      synchronous, active-low reset
// - in           in   DW     instruction word
// - load         in   1      capture in into IR (honoured only in WAIT)
// - s            in   1      start execution of IR (sampled only in WAIT)
// - w            out  1      1 = idle in WAIT, ready for s
// - err_illegal  out  1      sticky, undecodable instruction; cleared on next accepted s
// - loada/loadb/loadc/loads/asel/bsel/vsel/write  out 1 each  datapath strobes/selects
// - ALUop        out  2      ALU operation
// - shift        out  2      shifter control
// - readnum      out  RNUMW  regfile read index
// - writenum     out  RNUMW  regfile write index
// - datapath_in  out  DW     sign-extended imm8 for regfile writeback (vsel=1)
// BEHAVIOUR
// - Reset
//   - One clk with reset_n=0: state=WAIT, IR=0, err_illegal=0.
//   - All strobes, selects, ALUop, shift, readnum, writenum and datapath_in are 0; w=1.
//   - While reset_n=0, all strobes are gated low combinationally, so a reset mid-op never writes.
// - IR fields
//   - opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
//   - sximm8 = {{8{IR[7]}}, IR[7:0]}.
// - Outputs are Moore, a function of state and IR. Any output not listed for a state is 0.
// - WAIT
//   - w=1.
//   - load=1 captures IR<=in.
//   - s=1 -> DECODE. With load and s in the same cycle, DECODE sees the new IR.
// - DECODE (1 cycle)
//   - 110/10 -> WR_IMM.
//   - 110/00 -> GET_B.
//   - 101/xx -> GET_A.
//   - Otherwise: err_illegal<=1, -> WAIT.
// - WR_IMM: vsel=1, write=1, writenum=Rn, datapath_in=sximm8 -> WAIT.
// - GET_A: readnum=Rn, loada=1 -> GET_B.
// - GET_B: readnum=Rm, loadb=1 -> ALU.
// - ALU: shift=sh, bsel=0; asel=1 for MOV-reg (A input forced 0), else 0.
//   - ALUop=op for 101; ALUop=00 for MOV-reg.
//   - CMP (101/01): loads=1, loadc=0 -> WAIT.
//   - All others: loadc=1 -> WR_REG.
// - WR_REG: vsel=0, write=1, writenum=Rd -> WAIT.
// - Latency from s edge to w=1: MOV imm 2, CMP 4, MOV reg 4, ADD/AND/MVN 5 clks.
// - s or load outside WAIT is ignored, and IR stays stable for the whole instruction.
// - Encodings outside the decoded set are never silently executed.
// STRUCTURE
// - Package ctrl_pkg holds:
//   - state_t enum (WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG);
//   - opcode localparams OPC_MOV=3'b110, OPC_ALU=3'b101;
//   - ALUop localparams ADD/CMP/AND/MVN = 00/01/10/11;
//   - shift localparams.
// - One sub-module, instr_dec (combinational): IR -> fields, sximm8, class (imm/movreg/alu/illegal).
// - IR register, state register and output logic live in this module.
// TESTING
// - MOV R0,#42
//   - Stimulus: in=16'hD02A, load=s=1 for 1 clk.
//   - Response: DECODE, then WR_IMM with write=1, vsel=1, writenum=0, datapath_in=16'h002A; w=1 after 2 clks.
// - MOV R1,#-1
//   - Stimulus: in=16'hD1FF.
//   - Response: datapath_in=16'hFFFF in WR_IMM.
//   - Check: against the datapath, R1 ends as 16'hFFFF.
// - ADD R2,R1,R0,LSL#1
//   - Stimulus: in=16'hA148.
//   - Response: GET_A readnum=1 loada; GET_B readnum=0 loadb; ALU ALUop=00 shift=01 loadc; WR_REG writenum=2.
//   - Check: with R0=42, R1=-1, R2 ends as 16'h0053.
// - CMP R3,R3
//   - Stimulus: in=16'hAB03.
//   - Response: ALU state has loads=1, loadc=0; no write strobe ever; Z_out=1 afterwards; w=1 after 4 clks.
// - Illegal and ignored starts
//   - in=16'hE000 -> err_illegal=1, no strobe, back in WAIT.
//   - Next valid s clears err_illegal.
//   - s and load pulsed mid-ADD do not alter IR or flow.
// - Reset mid-op
//   - Stimulus: reset_n=0 during ALU state of ADD.
//   - Response: write never asserts; next clk state=WAIT, w=1, all outputs 0, IR=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the datapath control stage.
// Holds the FSM state type, instruction classes and opcode/ALU/shift encodings.
package ctrl_pkg;

    localparam int DW_DEF    = 16;
    localparam int RNUMW_DEF = 3;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WR_IMM,
        GET_A,
        GET_B,
        ALU,
        WR_REG
    } state_t;

    typedef enum logic [1:0] {
        CLS_IMM,
        CLS_MOVREG,
        CLS_ALU,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Sub-op field values under OPC_MOV
    localparam logic [1:0] MOV_OP_IMM = 2'b10;
    localparam logic [1:0] MOV_OP_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, sign-extends
// the 8-bit immediate and classifies the instruction.
module instr_dec
    import ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RNUMW = RNUMW_DEF
) (
    input  logic [DW-1:0]    ir,
    output logic [1:0]       op,
    output logic [RNUMW-1:0] rn,
    output logic [RNUMW-1:0] rd,
    output logic [1:0]       sh,
    output logic [RNUMW-1:0] rm,
    output logic [DW-1:0]    sximm8,
    output iclass_t          iclass
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[8 +: RNUMW];
    assign rd     = ir[5 +: RNUMW];
    assign sh     = ir[4:3];
    assign rm     = ir[0 +: RNUMW];

    assign sximm8[7:0] = ir[7:0];
    genvar gi;
    generate
        for (gi = 8; gi < DW; gi++) begin : g_sext
            assign sximm8[gi] = ir[7];
        end
    endgenerate

    // Anything not explicitly recognised is illegal and must never execute
    always_comb begin
        iclass = CLS_ILLEGAL;
        if (opcode == OPC_MOV && op == MOV_OP_IMM) begin
            iclass = CLS_IMM;
        end else if (opcode == OPC_MOV && op == MOV_OP_REG) begin
            iclass = CLS_MOVREG;
        end else if (opcode == OPC_ALU) begin
            iclass = CLS_ALU;
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Control stage for the register-file/ALU datapath: latches an instruction,
// decodes it and sequences a Moore FSM that drives every datapath strobe.
module datapath_controller
    import ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int RNUMW = RNUMW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DW-1:0]    in,
    input  logic             load,
    input  logic             s,
    output logic             w,
    output logic             err_illegal,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic             vsel,
    output logic             write,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [RNUMW-1:0] readnum,
    output logic [RNUMW-1:0] writenum,
    output logic [DW-1:0]    datapath_in
);

    state_t          state_reg, state_next;
    logic [DW-1:0]   ir_reg;
    logic            err_reg;

    logic [1:0]       op;
    logic [RNUMW-1:0] rn, rd, rm;
    logic [1:0]       sh;
    logic [DW-1:0]    sximm8;
    iclass_t          iclass;
    logic             is_cmp;

    logic             loada_raw, loadb_raw, loadc_raw, loads_raw;
    logic             asel_raw, bsel_raw, vsel_raw, write_raw;
    logic [1:0]       aluop_raw, shift_raw;
    logic [RNUMW-1:0] readnum_raw, writenum_raw;
    logic [DW-1:0]    datapath_in_raw;

    instr_dec #(
        .DW    (DW),
        .RNUMW (RNUMW)
    ) u_dec (
        .ir     (ir_reg),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .iclass (iclass)
    );

    assign is_cmp = (iclass == CLS_ALU) && (op == ALU_CMP);

    // IR and the error flag only move while idle, so they hold for the whole instruction
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= WAIT;
            ir_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT && load) begin
                ir_reg <= in;
            end
            if (state_reg == WAIT && s) begin
                err_reg <= 1'b0;
            end else if (state_reg == DECODE && iclass == CLS_ILLEGAL) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT:   if (s) state_next = DECODE;
            DECODE: begin
                case (iclass)
                    CLS_IMM:    state_next = WR_IMM;
                    CLS_MOVREG: state_next = GET_B;
                    CLS_ALU:    state_next = GET_A;
                    default:    state_next = WAIT;
                endcase
            end
            WR_IMM: state_next = WAIT;
            GET_A:  state_next = GET_B;
            GET_B:  state_next = ALU;
            ALU:    state_next = is_cmp ? WAIT : WR_REG;
            WR_REG: state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        loada_raw       = 1'b0;
        loadb_raw       = 1'b0;
        loadc_raw       = 1'b0;
        loads_raw       = 1'b0;
        asel_raw        = 1'b0;
        bsel_raw        = 1'b0;
        vsel_raw        = 1'b0;
        write_raw       = 1'b0;
        aluop_raw       = ALU_ADD;
        shift_raw       = SH_NONE;
        readnum_raw     = '0;
        writenum_raw    = '0;
        datapath_in_raw = '0;
        case (state_reg)
            WR_IMM: begin
                vsel_raw        = 1'b1;
                write_raw       = 1'b1;
                writenum_raw    = rn;
                datapath_in_raw = sximm8;
            end
            GET_A: begin
                readnum_raw = rn;
                loada_raw   = 1'b1;
            end
            GET_B: begin
                readnum_raw = rm;
                loadb_raw   = 1'b1;
            end
            ALU: begin
                shift_raw = sh;
                // MOV-reg passes the shifted B through an adder with A forced to zero
                asel_raw  = (iclass == CLS_MOVREG);
                aluop_raw = (iclass == CLS_ALU) ? op : ALU_ADD;
                loads_raw = is_cmp;
                loadc_raw = !is_cmp;
            end
            WR_REG: begin
                write_raw    = 1'b1;
                writenum_raw = rd;
            end
            default: ;
        endcase
    end

    // Reset gates everything combinationally so an aborted instruction never writes
    assign {loada, loadb, loadc, loads, asel, bsel, vsel, write,
            ALUop, shift, readnum, writenum, datapath_in} =
        reset_n ? {loada_raw, loadb_raw, loadc_raw, loads_raw,
                   asel_raw, bsel_raw, vsel_raw, write_raw,
                   aluop_raw, shift_raw, readnum_raw, writenum_raw, datapath_in_raw}
                : '0;

    assign w           = (state_reg == WAIT);
    assign err_illegal = err_reg;

endmodule
